// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-transfer encodings, FSM states and reset/vector defaults.
package cpu_pkg;

  typedef enum logic [1:0] {
    CTI_NONE = 2'd0,
    CTI_BR   = 2'd1,
    CTI_J    = 2'd2,
    CTI_JR   = 2'd3
  } cti_e;

  typedef enum logic {
    NPC_SEQ   = 1'b0,
    NPC_DSLOT = 1'b1
  } npc_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

  // Branch displacement in bytes: word offset sign-extended and scaled by 4.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_target.sv
// Combinational control-transfer target calculator for the next-PC unit.
module npc_target
  import cpu_pkg::*;
(
  input  logic [1:0]  cti,
  input  logic        br_taken,
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_val,
  output logic [31:0] target
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  // NOTE: target gets a value before the case so no path leaves it unassigned (no latch).
  always_comb begin
    target = pc_plus4;
    case (cti_e'(cti))
      CTI_BR:  target = br_taken ? pc_plus4 + branch_offset(imm16) : pc + 32'd8;
      CTI_J:   target = {pc_plus4[31:28], index26, 2'b00};
      CTI_JR:  target = rs_val;
      default: target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/npc_unit.sv
// Next-PC unit with one-instruction delay slot; define NPC_EXC_EN to add the
// exception entry / eret return path (exc_req, eret, epc, bd).
module npc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic [1:0]  cti,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_val,
  output logic [31:0] next_pc,
  output logic [31:0] link_addr,
  output logic        in_dslot,
  output logic        cti_err
`ifdef NPC_EXC_EN
  ,
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] epc,
  output logic        bd
`endif
);

  npc_state_e  state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] target;

  npc_target u_target (
    .cti      (cti),
    .br_taken (br_taken),
    .pc       (pc),
    .imm16    (imm16),
    .index26  (index26),
    .rs_val   (rs_val),
    .target   (target)
  );

  assign link_addr = pc + 32'd8;
  assign in_dslot  = (state_q == NPC_DSLOT);

  // Later assignments override earlier ones, giving reset > exc_req > eret > stall > FSM.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    next_pc = pc + 32'd4;
    cti_err = 1'b0;

    if (state_q == NPC_DSLOT) begin
      next_pc = tgt_q;
      cti_err = (cti_e'(cti) != CTI_NONE);
      state_d = NPC_SEQ;
    end else if (cti_e'(cti) != CTI_NONE) begin
      state_d = NPC_DSLOT;
      tgt_d   = target;
    end

    if (stall) begin
      next_pc = pc;
      state_d = state_q;
      tgt_d   = tgt_q;
    end

`ifdef NPC_EXC_EN
    if (eret) begin
      next_pc = epc;
      state_d = NPC_SEQ;
      tgt_d   = tgt_q;
    end

    if (exc_req) begin
      next_pc = EXC_VEC;
      state_d = NPC_SEQ;
      tgt_d   = tgt_q;
    end
`endif

    if (reset) begin
      next_pc = RESET_PC;
      state_d = NPC_SEQ;
      tgt_d   = '0;
      cti_err = 1'b0;
    end
  end

  // NOTE: registered state uses non-blocking assignments; reset is folded into state_d.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    tgt_q   <= tgt_d;
  end

`ifdef NPC_EXC_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      epc <= RESET_PC;
      bd  <= 1'b0;
    end else if (exc_req) begin
      epc <= in_dslot ? pc - 32'd4 : pc;
      bd  <= in_dslot;
    end
  end
`else
  // The exception vector has no consumer when the exception path is compiled out.
  logic unused_exc_vec;
  assign unused_exc_vec = ^EXC_VEC;
`endif

endmodule

// File: tb/tb_npc_unit.sv
// Self-checking bench for npc_unit: directed vectors, a cycle-level reference
// model compared every cycle, and hand-computed literal expectations.
module tb_npc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = RESET_PC;
  logic        stall = 1'b0;
  logic [1:0]  cti = 2'd0;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] index26 = '0;
  logic [31:0] rs_val = '0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] next_pc, link_addr;
  logic        in_dslot, cti_err;
  logic [31:0] epc;
  logic        bd;

  int checks = 0;
  int errors = 0;

  npc_unit #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .stall     (stall),
    .cti       (cti),
    .br_taken  (br_taken),
    .imm16     (imm16),
    .index26   (index26),
    .rs_val    (rs_val),
    .next_pc   (next_pc),
    .link_addr (link_addr),
    .in_dslot  (in_dslot),
    .cti_err   (cti_err)
`ifdef NPC_EXC_EN
    ,
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
    .bd        (bd)
`endif
  );

`ifndef NPC_EXC_EN
  assign epc = RESET_PC;
  assign bd  = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: "a transfer was accepted last instruction" plus the address it owes.
  logic        started = 1'b0;
  logic        m_slot = 1'b0;
  logic [31:0] m_tgt = '0;
  logic [31:0] m_epc = RESET_PC;
  logic        m_bd = 1'b0;

  function automatic logic [31:0] model_target(input logic [1:0] c, input logic t,
      input logic [31:0] p, input logic [15:0] im, input logic [25:0] ix, input logic [31:0] rs);
    int off;
    off = int'($signed(im)) * 4;
    case (c)
      2'd1:    return t ? p + 32'd4 + 32'(off) : p + 32'd8;
      2'd2:    return ((p + 32'd4) & 32'hF000_0000) | (32'(ix) * 32'd4);
      2'd3:    return rs;
      default: return p + 32'd4;
    endcase
  endfunction

  function automatic logic [31:0] model_npc();
    logic exc_on;
`ifdef NPC_EXC_EN
    exc_on = 1'b1;
`else
    exc_on = 1'b0;
`endif
    if (reset) return RESET_PC;
    if (exc_on && exc_req) return EXC_VEC;
    if (exc_on && eret) return m_epc;
    if (stall) return pc;
    return m_slot ? m_tgt : pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started <= 1'b1;
      m_slot  <= 1'b0;
      m_tgt   <= '0;
      m_epc   <= RESET_PC;
      m_bd    <= 1'b0;
`ifdef NPC_EXC_EN
    end else if (exc_req) begin
      m_epc  <= m_slot ? pc - 32'd4 : pc;
      m_bd   <= m_slot;
      m_slot <= 1'b0;
    end else if (eret) begin
      m_slot <= 1'b0;
`endif
    end else if (!stall) begin
      if (m_slot) m_slot <= 1'b0;
      else if (cti != 2'd0) begin
        m_slot <= 1'b1;
        m_tgt  <= model_target(cti, br_taken, pc, imm16, index26, rs_val);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_next_pc", next_pc, model_npc());
      check("model_link_addr", link_addr, pc + 32'd8);
      check("model_in_dslot", 32'(in_dslot), 32'(m_slot));
      check("model_cti_err", 32'(cti_err), 32'(m_slot && cti != 2'd0 && !reset));
`ifdef NPC_EXC_EN
      check("model_epc", epc, m_epc);
      check("model_bd", 32'(bd), 32'(m_bd));
`endif
    end
  end

  // Applies one cycle of inputs just after a posedge; outputs settle before the caller checks.
  task automatic step(input logic r, input logic st, input logic [31:0] p, input logic [1:0] c,
      input logic bt, input logic [15:0] im, input logic [25:0] ix, input logic [31:0] rs,
      input logic ex, input logic er);
    @(posedge clk);
    #1;
    reset = r; stall = st; pc = p; cti = c; br_taken = bt;
    imm16 = im; index26 = ix; rs_val = rs; exc_req = ex; eret = er;
    #1;
  endtask

  task automatic seq(input logic [31:0] p);
    step(0, 0, p, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
  endtask

  initial begin
    step(1, 0, 32'h3000, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    step(1, 0, 32'h3000, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    check("reset_next_pc", next_pc, 32'h3000);
    check("reset_in_dslot", 32'(in_dslot), 32'd0);
    check("reset_cti_err", 32'(cti_err), 32'd0);

    // Branch taken, positive offset.
    step(0, 0, 32'h3000, 2'd1, 1, 16'h0003, 26'h0, 32'h0, 0, 0);
    check("br_npc", next_pc, 32'h3004);
    check("br_link", link_addr, 32'h3008);
    seq(32'h3004);
    check("br_slot_flag", 32'(in_dslot), 32'd1);
    check("br_slot_npc", next_pc, 32'h3010);
    seq(32'h3010);
    check("br_after_slot", 32'(in_dslot), 32'd0);

    // Negative offset, then not taken.
    step(0, 0, 32'h3020, 2'd1, 1, 16'hFFFE, 26'h0, 32'h0, 0, 0);
    seq(32'h3024);
    check("br_neg_tgt", next_pc, 32'h301C);
    step(0, 0, 32'h3020, 2'd1, 0, 16'hFFFE, 26'h0, 32'h0, 0, 0);
    seq(32'h3024);
    check("br_nt_tgt", next_pc, 32'h3028);

    // Jump-register held by a two-cycle stall.
    step(0, 1, 32'h3000, 2'd3, 0, 16'h0, 26'h0, 32'h3400, 0, 0);
    check("jr_stall1", next_pc, 32'h3000);
    step(0, 1, 32'h3000, 2'd3, 0, 16'h0, 26'h0, 32'h3400, 0, 0);
    check("jr_stall2", next_pc, 32'h3000);
    check("jr_stall_state", 32'(in_dslot), 32'd0);
    step(0, 0, 32'h3000, 2'd3, 0, 16'h0, 26'h0, 32'h3400, 0, 0);
    check("jr_npc", next_pc, 32'h3004);
    seq(32'h3004);
    check("jr_tgt", next_pc, 32'h3400);

    // Jump followed by a jump in its delay slot.
    step(0, 0, 32'h3000, 2'd2, 0, 16'h0, 26'h0000D00, 32'h0, 0, 0);
    step(0, 0, 32'h3004, 2'd2, 0, 16'h0, 26'h3FFFFFF, 32'h0, 0, 0);
    check("dslot_cti_err", 32'(cti_err), 32'd1);
    check("dslot_orig_tgt", next_pc, 32'h3400);
    seq(32'h3400);
    check("dslot_err_cleared", 32'(cti_err), 32'd0);
    check("dslot_seq_npc", next_pc, 32'h3404);

    // Address wrap-around.
    seq(32'hFFFF_FFFC);
    check("wrap_npc", next_pc, 32'h0);
    check("wrap_link", link_addr, 32'h4);
    step(0, 0, 32'hFFFF_FFFC, 2'd1, 1, 16'h0001, 26'h0, 32'h0, 0, 0);
    seq(32'h0);
    check("wrap_br_tgt", next_pc, 32'h4);

    // Jump keeps the upper nibble of pc+4, which crosses a region here.
    step(0, 0, 32'hAFFF_FFFC, 2'd2, 0, 16'h0, 26'h3FFFFFF, 32'h0, 0, 0);
    seq(32'hB000_0000);
    check("j_region_tgt", next_pc, 32'hBFFF_FFFC);

    // Stall while sitting in the delay slot.
    step(0, 0, 32'h3000, 2'd1, 1, 16'h0003, 26'h0, 32'h0, 0, 0);
    step(0, 1, 32'h3004, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    check("slot_stall_npc", next_pc, 32'h3004);
    check("slot_stall_flag", 32'(in_dslot), 32'd1);
    seq(32'h3004);
    check("slot_stall_tgt", next_pc, 32'h3010);

    // Reset taken while in a delay slot.
    step(0, 0, 32'h300C, 2'd1, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    step(1, 0, 32'h3010, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    check("reset_dslot_npc", next_pc, 32'h3000);
    seq(32'h3000);
    check("reset_dslot_cleared", 32'(in_dslot), 32'd0);
    check("reset_dslot_seq", next_pc, 32'h3004);

`ifdef NPC_EXC_EN
    step(0, 0, 32'h3000, 2'd1, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    step(0, 0, 32'h3004, 2'd0, 0, 16'h0, 26'h0, 32'h0, 1, 0);
    check("exc_npc", next_pc, 32'h4180);
    seq(32'h4180);
    check("exc_epc", epc, 32'h3000);
    check("exc_bd", 32'(bd), 32'd1);
    check("exc_seq", 32'(in_dslot), 32'd0);
    step(0, 0, 32'h4184, 2'd0, 0, 16'h0, 26'h0, 32'h0, 0, 1);
    check("eret_npc", next_pc, 32'h3000);
    seq(32'h3000);
    check("eret_seq", next_pc, 32'h3004);
`endif

    seq(32'h3004);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npc_unit.md
NPC_UNIT -- requirements
Module: npc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h00003000: fetch address after reset.
REQ-002 SHALL have parameter EXC_VEC, 32'h00004180: exception handler entry address.
REQ-003 SHALL have port clk  input  1: clock; all state updates on the posedge.
REQ-004 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port pc  input  32: current fetch address, from the PC register.
REQ-006 SHALL have port stall  input  1: hold the fetch address and the FSM state.
REQ-007 SHALL have port cti  input  2: control transfer at pc; 0 none, 1 branch, 2 jump (j/jal), 3 jump-register.
REQ-008 SHALL have port br_taken  input  1: branch condition result, valid when cti==1.
REQ-009 SHALL have port imm16  input  16: branch offset.
REQ-010 SHALL have port index26  input  26: jump index.
REQ-011 SHALL have port rs_val  input  32: jump-register target.
REQ-012 SHALL have port next_pc  output  32: address the PC register loads on the next posedge.
REQ-013 SHALL have port link_addr  output  32: pc+8, the jal/jalr return address.
REQ-014 SHALL have port in_dslot  output  1: pc is a delay-slot instruction.
REQ-015 SHALL have port cti_err  output  1: a control transfer was decoded inside a delay slot.

Function
REQ-016 SHALL implement a 2-state FSM, SEQ and DSLOT, plus a 32-bit target register tgt.
REQ-017 SHALL, in SEQ with cti!=0 and no stall, drive next_pc=pc+4, load tgt and go to DSLOT.
- Branch taken: tgt = pc+4+(sign-extended imm16<<2).
- Branch not taken: tgt = pc+8.
- Jump: tgt = {pc+4[31:28], index26, 2'b00}.
- Jump-register: tgt = rs_val.
REQ-018 SHALL, in SEQ with cti==0, drive next_pc=pc+4 and stay in SEQ.
REQ-019 SHALL, in DSLOT without stall, drive next_pc=tgt and return to SEQ.
REQ-020 SHALL, in DSLOT with cti!=0, ignore the transfer and pulse cti_err high for that cycle.
REQ-021 SHALL, when stall=1, drive next_pc=pc and leave the state and tgt unchanged.
REQ-022 SHALL compute all address arithmetic modulo 2^32; wrap-around from 32'hFFFFFFFC is legal.
REQ-023 SHALL keep next_pc, link_addr, in_dslot and cti_err combinational from the inputs and current state, with 0-cycle latency.
REQ-024 SHALL set in_dslot=1 exactly while in DSLOT.

Reset
REQ-025 SHALL drive next_pc=RESET_PC while reset=1.
REQ-026 SHALL on reset go to SEQ, clear tgt to 0, hold cti_err=0, and take reset over every other input, including mid-DSLOT.

Configuration
REQ-027 SHALL, with NPC_EXC_EN defined, add these ports:
- exc_req input 1
- eret input 1
- epc output 32
- bd output 1
REQ-028 SHALL, on exc_req, drive next_pc=EXC_VEC and go to SEQ.
- Latch epc = pc, or pc-4 when in DSLOT.
- Latch bd = in_dslot.
REQ-029 SHALL, on eret, drive next_pc=epc and go to SEQ.
REQ-030 SHALL apply the priority reset > exc_req > eret > stall > FSM.
REQ-031 SHALL reset epc to RESET_PC and bd to 0.
REQ-032 SHALL, without NPC_EXC_EN, omit these ports and the logic behind them and behave exactly as REQ-016..026.

Structure
REQ-033 SHALL take the cti encodings, RESET_PC and EXC_VEC defaults from the shared package cpu_pkg.
REQ-034 SHALL use one sub-module, npc_target: a combinational target calculator fed by cti, br_taken, pc, imm16, index26 and rs_val.

Verification
REQ-035 SHALL cover reset: reset=1 at pc=0x3010 in DSLOT -> next_pc=0x3000; in_dslot=0 on the following cycle.
REQ-036 SHALL cover branch taken: pc=0x3000, cti=1, br_taken=1, imm16=0x0003 -> next_pc=0x3004, then at pc=0x3004 next_pc=0x3010.
REQ-037 SHALL cover negative offset and not-taken:
- Taken: pc=0x3020, imm16=0xFFFE -> tgt=0x301C.
- Not taken: pc=0x3020 -> tgt=0x3028.
REQ-038 SHALL cover jr under stall: pc=0x3000, cti=3, rs_val=0x3400, stall=1 for 2 cycles -> next_pc=0x3000 both cycles; then 0x3004, then 0x3400.
REQ-039 SHALL cover a transfer in the delay slot: cti=2 while in DSLOT -> cti_err=1 for one cycle; next_pc=original tgt.
REQ-040 SHALL cover exceptions when NPC_EXC_EN is defined:
- exc_req at pc=0x3004 in DSLOT -> next_pc=0x4180, epc=0x3000, bd=1.
- Subsequent eret -> next_pc=0x3000.
